seq_match_stats: RTL and testbench

- Downstream consumer of the 011100 group sequence detector.
- Takes its per-group match / not_match pulses, one pulse per 6-bit group, and accumulates per-window statistics: match count, miss count and longest consecutive-match run.
- At the end of each window of WIN_GROUPS groups, presents one report on a valid/ready interface with a single-entry holding buffer.
- Flags overflow and protocol errors with sticky bits.

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_rpt_slot.sv | 62 ++++++
 rtl/seq_match_stats.sv | 119 +++++++++++
 tb/tb_seq_match_stats.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the group-sequence statistics blocks: the report record
// that travels through the holding slot and the slot state encoding.
package seq_pkg;

    // Width of every count field carried in a report.
    localparam int RPT_CNT_W = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [RPT_CNT_W-1:0] match_cnt;
        logic [RPT_CNT_W-1:0] miss_cnt;
        logic [RPT_CNT_W-1:0] max_run;
    } rpt_t;

endpackage : seq_pkg

// File: rtl/seq_rpt_slot.sv
// One-entry valid/ready holding register. A new payload overwrites the held
// one only when the consumer accepts in the same cycle; otherwise it is
// dropped and the sticky overflow flag is raised.
module seq_rpt_slot
    import seq_pkg::*;
#(
    parameter type payload_t = rpt_t
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr_i,
    input  logic     load_i,
    input  payload_t data_i,
    input  logic     ready_i,
    output logic     valid_o,
    output payload_t data_o,
    output logic     ovf_o
);

    slot_state_e state_q;
    payload_t    data_q;
    logic        ovf_q;

    // Slot FSM: load, hand off, overwrite-on-accept or drop with overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (clr_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                SLOT_EMPTY: begin
                    if (load_i) begin
                        data_q  <= data_i;
                        state_q <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (ready_i && load_i) begin
                        data_q <= data_i;
                    end else if (ready_i) begin
                        state_q <= SLOT_EMPTY;
                    end else if (load_i) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;
    assign ovf_o   = ovf_q;

endmodule : seq_rpt_slot

// File: rtl/seq_match_stats.sv
// Per-window statistics over the 011100 group detector's match/not_match
// pulses: match count, miss count and longest consecutive-match run, reported
// once per WIN_GROUPS groups through a one-entry valid/ready slot.
module seq_match_stats
    import seq_pkg::*;
#(
    parameter int WIN_GROUPS = 8,
    parameter int CNT_W      = RPT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             match,
    input  logic             not_match,
    input  logic             clr,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_match_cnt,
    output logic [CNT_W-1:0] rpt_miss_cnt,
    output logic [CNT_W-1:0] rpt_max_run,
    output logic             ovf,
    output logic             proto_err
);

    // Counts are sized so a full window can never wrap them.
    if (WIN_GROUPS < 1 || WIN_GROUPS >= (1 << CNT_W) || CNT_W != RPT_CNT_W) begin : g_param_check
        $error("seq_match_stats: need 1 <= WIN_GROUPS < 2**CNT_W and CNT_W == RPT_CNT_W");
    end

    logic [CNT_W-1:0] grp_cnt_q, acc_match_q, acc_miss_q, run_q, max_run_q;
    logic [CNT_W-1:0] grp_cnt_d, acc_match_d, acc_miss_d, run_d, max_run_d;
    logic             proto_err_q;

    logic             ev, is_match, is_miss, win_close;
    logic [CNT_W-1:0] run_inc;
    rpt_t             close_rpt;
    rpt_t             slot_rpt;

    // A simultaneous match/not_match is a protocol error and counts as a miss.
    assign ev        = match | not_match;
    assign is_miss   = not_match;
    assign is_match  = match & ~not_match;
    assign win_close = ev && (grp_cnt_q == CNT_W'(WIN_GROUPS - 1));
    assign run_inc   = run_q + CNT_W'(1);

    // Accumulator next state; the closing report includes the current event.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        grp_cnt_d   = grp_cnt_q;
        acc_match_d = acc_match_q;
        acc_miss_d  = acc_miss_q;
        run_d       = run_q;
        max_run_d   = max_run_q;
        if (ev) begin
            grp_cnt_d = grp_cnt_q + CNT_W'(1);
            if (is_match) begin
                acc_match_d = acc_match_q + CNT_W'(1);
                run_d       = run_inc;
                if (run_inc > max_run_q) max_run_d = run_inc;
            end else begin
                acc_miss_d = acc_miss_q + CNT_W'(1);
                run_d      = '0;
            end
        end
        close_rpt.match_cnt = acc_match_d;
        close_rpt.miss_cnt  = acc_miss_d;
        close_rpt.max_run   = max_run_d;
    end

    // Window accumulators: cleared by clr or at window close, runs never span windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_cnt_q   <= '0;
            acc_match_q <= '0;
            acc_miss_q  <= '0;
            run_q       <= '0;
            max_run_q   <= '0;
        end else if (clr || win_close) begin
            grp_cnt_q   <= '0;
            acc_match_q <= '0;
            acc_miss_q  <= '0;
            run_q       <= '0;
            max_run_q   <= '0;
        end else begin
            grp_cnt_q   <= grp_cnt_d;
            acc_match_q <= acc_match_d;
            acc_miss_q  <= acc_miss_d;
            run_q       <= run_d;
            max_run_q   <= max_run_d;
        end
    end

    // Sticky protocol-error flag, cleared only by clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     proto_err_q <= 1'b0;
        else if (clr)                   proto_err_q <= 1'b0;
        else if (match && not_match)    proto_err_q <= 1'b1;
    end

    seq_rpt_slot #(
        .payload_t (rpt_t)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .load_i  (win_close & ~clr),
        .data_i  (close_rpt),
        .ready_i (rpt_ready),
        .valid_o (rpt_valid),
        .data_o  (slot_rpt),
        .ovf_o   (ovf)
    );

    assign rpt_match_cnt = slot_rpt.match_cnt;
    assign rpt_miss_cnt  = slot_rpt.miss_cnt;
    assign rpt_max_run   = slot_rpt.max_run;
    assign proto_err     = proto_err_q;

endmodule : seq_match_stats

// File: tb/tb_seq_match_stats.sv
// Directed bench for seq_match_stats with hand-computed window reports.
module tb_seq_match_stats;

    logic       clk;
    logic       rst_n;
    logic       match;
    logic       not_match;
    logic       clr;
    logic       rpt_valid;
    logic       rpt_ready;
    logic [3:0] rpt_match_cnt;
    logic [3:0] rpt_miss_cnt;
    logic [3:0] rpt_max_run;
    logic       ovf;
    logic       proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    seq_match_stats #(
        .WIN_GROUPS (8),
        .CNT_W      (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .match         (match),
        .not_match     (not_match),
        .clr           (clr),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rpt_ready),
        .rpt_match_cnt (rpt_match_cnt),
        .rpt_miss_cnt  (rpt_miss_cnt),
        .rpt_max_run   (rpt_max_run),
        .ovf           (ovf),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_rpt(input string tag, input logic v, input int m, input int mi, input int r);
        check({tag, ".valid"}, 32'(rpt_valid), 32'(v));
        check({tag, ".match_cnt"}, 32'(rpt_match_cnt), m);
        check({tag, ".miss_cnt"}, 32'(rpt_miss_cnt), mi);
        check({tag, ".max_run"}, 32'(rpt_max_run), r);
    endtask

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle for gap cycles, then drive one group pulse for one cycle.
    task automatic send(input logic m, input logic n, input int gap);
        repeat (gap) tick();
        match     = m;
        not_match = n;
        tick();
        match     = 1'b0;
        not_match = 1'b0;
    endtask

    // Eight groups, MSB first: 1 = match, 0 = miss.
    task automatic send_window(input logic [7:0] pat, input int gap);
        for (int i = 7; i >= 0; i--) send(pat[i], ~pat[i], gap);
    endtask

    task automatic consume();
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        match     = 1'b0;
        not_match = 1'b0;
        clr       = 1'b0;
        rpt_ready = 1'b0;
        #12;
        check_rpt("reset", 1'b0, 0, 0, 0);
        check("reset.ovf", 32'(ovf), 0);
        check("reset.proto_err", 32'(proto_err), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Eight matches spaced 6 cycles apart.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("all_m.pre_close_valid", 32'(rpt_valid), 0);
            send(1'b1, 1'b0, 5);
        end
        check_rpt("all_m", 1'b1, 8, 0, 8);
        consume();
        check("all_m.consumed_valid", 32'(rpt_valid), 0);
        check("all_m.ovf", 32'(ovf), 0);

        // M M N M M M N N, back-to-back events.
        send_window(8'b1101_1100, 0);
        check_rpt("mix", 1'b1, 5, 3, 3);
        consume();
        // All misses: max_run must not carry over.
        send_window(8'b0000_0000, 1);
        check_rpt("all_n", 1'b1, 0, 8, 0);
        consume();

        // Two windows with ready held low: second report dropped.
        send_window(8'b1111_1111, 1);
        check("hold.first_ovf", 32'(ovf), 0);
        send_window(8'b0000_0000, 1);
        check_rpt("hold", 1'b1, 8, 0, 8);
        check("hold.ovf", 32'(ovf), 1);
        consume();
        check("hold.consumed_valid", 32'(rpt_valid), 0);
        check("hold.ovf_sticky", 32'(ovf), 1);
        do_clr();
        check("hold.clr_ovf", 32'(ovf), 0);

        // Accept in the same cycle as the next close: overwrite, no drop.
        send_window(8'b1101_1100, 1);
        check_rpt("ovr.first", 1'b1, 5, 3, 3);
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 1);
        tick();
        rpt_ready = 1'b1;
        match     = 1'b1;
        tick();
        rpt_ready = 1'b0;
        match     = 1'b0;
        check_rpt("ovr.second", 1'b1, 8, 0, 8);
        check("ovr.ovf", 32'(ovf), 0);
        consume();

        // Both inputs high on group 3: counted as a miss, proto_err set.
        send(1'b1, 1'b0, 1);
        send(1'b1, 1'b0, 1);
        send(1'b1, 1'b1, 1);
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1);
        check_rpt("proto", 1'b1, 7, 1, 5);
        check("proto.err", 32'(proto_err), 1);
        do_clr();
        check_rpt("proto.clr", 1'b0, 0, 0, 0);
        check("proto.clr_err", 32'(proto_err), 0);

        // Reset mid-window: partial window is lost.
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 1);
        check("rst_mid.no_partial", 32'(rpt_valid), 0);
        send(1'b1, 1'b0, 1);
        check_rpt("rst_mid", 1'b1, 8, 0, 8);
        consume();

        // clr coincident with a pulse: that pulse is discarded.
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 1);
        tick();
        clr   = 1'b1;
        match = 1'b1;
        tick();
        clr   = 1'b0;
        match = 1'b0;
        check("clr_ev.no_close", 32'(rpt_valid), 0);
        send(1'b0, 1'b1, 1);
        check("clr_ev.one_group", 32'(rpt_valid), 0);
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 1);
        check_rpt("clr_ev", 1'b1, 7, 1, 7);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_match_stats
